nios_system_packet_ring_buffer: RTL and testbench

Parametrised packet buffer that replaces the fixed 1024×32 single-port packet RAM with a ring-buffered, packet-aware store. A streaming sink writes whole packets into on-chip RAM. The Nios II reads them through a small Avalon-MM register window. Only complete packets become visible to the CPU, and packets that do not fit are dropped whole.

---
 rtl/nios_system_packet_ring_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_nios_system_packet_ring_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_packet_ring_buffer.sv
// Packet-aware ring buffer between a streaming sink and an Avalon-MM slave.
// Whole packets are written into a dual-port RAM; only committed packets
// become visible to the CPU, and packets that do not fit are dropped whole.
module nios_system_packet_ring_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int LEN_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    output logic                  in_ready,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  readdatavalid
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = $clog2(LEN_FIFO_DEPTH);
    localparam int CW    = LW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} wstate_t;

    wstate_t               state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         head_rem_q, head_rem_d;
    logic [LW-1:0]         len_wp_q, len_wp_d, len_rp_q, len_rp_d;
    logic [CW-1:0]         len_cnt_q, len_cnt_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d, proto_q, proto_d;
    logic                  in_ready_q;
    logic                  rd_sel_q, rd_sel_d, rdvalid_q;
    logic [31:0]           rd_reg_q, rd_reg_d, status;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [PW-1:0]         len_mem [LEN_FIFO_DEPTH];

    // Bus and stream decode shared by the FSM and the datapath.
    logic          rd_en, wr_en, ctrl_wr, flush, clear, data_rd, pop_data, underflow;
    logic          beat, restart, room, accept, do_write, ovf_drop, commit_try;
    logic          fifo_pop, commit_ok, commit_refused;
    logic [PW-1:0] fill, wr_base, wr_next, push_len;
    logic          unused_wdata;

    assign rd_en      = chipselect & read & ~write;
    assign wr_en      = chipselect & write;
    assign ctrl_wr    = wr_en & (address == 2'd3);
    assign flush      = ctrl_wr & writedata[1];
    assign clear      = ctrl_wr & writedata[0];
    assign fill       = wr_commit_q - rd_ptr_q;
    assign data_rd    = rd_en & (address == 2'd2);
    assign pop_data   = data_rd & (fill != '0);
    assign underflow  = data_rd & (fill == '0);
    // A flush in the same cycle discards the beat.
    assign beat       = in_valid & in_ready_q & ~flush;
    // sop inside an open packet restarts it from the last commit point.
    assign restart    = beat & in_startofpacket & (state_q == S_FILL);
    assign wr_base    = restart ? wr_commit_q : wr_ptr_q;
    assign room       = (wr_base - rd_ptr_q) < DEPTH_P;
    assign accept     = beat & (((state_q == S_IDLE) & in_startofpacket) | (state_q == S_FILL));
    assign do_write   = accept & room;
    assign ovf_drop   = accept & ~room;
    assign commit_try = do_write & in_endofpacket;
    // Reading the final word of the head packet frees a length slot this cycle.
    assign fifo_pop   = pop_data & (head_rem_q == PW'(1));
    assign commit_ok  = commit_try & ((len_cnt_q != CW'(LEN_FIFO_DEPTH)) | fifo_pop);
    assign commit_refused = commit_try & ~commit_ok;
    assign wr_next    = wr_base + PW'(1);
    assign push_len   = wr_next - wr_commit_q;
    assign unused_wdata = ^writedata[31:2];

    assign in_ready      = in_ready_q;
    assign readdatavalid = rdvalid_q;
    assign readdata      = rd_sel_q ? 32'(ram_q) : rd_reg_q;

    // Packet RAM: write port from the stream, registered read port for DATA pops.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_base[ADDR_WIDTH-1:0]] <= in_data;
        if (pop_data) ram_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    // Length FIFO storage: one entry per committed packet.
    always_ff @(posedge clk) begin
        if (commit_ok) len_mem[len_wp_q] <= push_len;
    end

    // State register for the write FSM and all control/status flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            head_rem_q  <= '0;
            len_wp_q    <= '0;
            len_rp_q    <= '0;
            len_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            proto_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_reg_q    <= '0;
            rdvalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            head_rem_q  <= head_rem_d;
            len_wp_q    <= len_wp_d;
            len_rp_q    <= len_rp_d;
            len_cnt_q   <= len_cnt_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            proto_q     <= proto_d;
            in_ready_q  <= 1'b1;
            rd_sel_q    <= rd_sel_d;
            rd_reg_q    <= rd_reg_d;
            rdvalid_q   <= rd_en;
        end
    end

    // Write FSM next state: open on sop, close on eop, drop on overflow or flush.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            if (state_q == S_FILL) state_d = S_DROP;
        end else if (accept) begin
            if (in_endofpacket) state_d = S_IDLE;
            else if (room)      state_d = S_FILL;
            else                state_d = S_DROP;
        end else if (beat && state_q == S_DROP && in_endofpacket) begin
            state_d = S_IDLE;
        end
    end

    // Pointer, length FIFO and sticky flag updates driven by the FSM decode.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        rd_ptr_d    = rd_ptr_q;
        head_rem_d  = head_rem_q;
        len_wp_d    = len_wp_q;
        len_rp_d    = len_rp_q;
        len_cnt_d   = len_cnt_q;
        if (flush) begin
            wr_ptr_d    = '0;
            wr_commit_d = '0;
            rd_ptr_d    = '0;
            head_rem_d  = '0;
            len_wp_d    = '0;
            len_rp_d    = '0;
            len_cnt_d   = '0;
        end else begin
            if (do_write)                  wr_ptr_d    = wr_next;
            if (commit_ok)                 wr_commit_d = wr_next;
            if (commit_refused | ovf_drop) wr_ptr_d    = wr_commit_q;
            if (pop_data)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (commit_ok) len_wp_d = len_wp_q + LW'(1);
            if (fifo_pop)  len_rp_d = len_rp_q + LW'(1);
            len_cnt_d = len_cnt_q + CW'(commit_ok) - CW'(fifo_pop);
            if (pop_data) head_rem_d = head_rem_q - PW'(1);
            if (fifo_pop) begin
                if (len_cnt_q > CW'(1)) head_rem_d = len_mem[len_rp_q + LW'(1)];
                else if (commit_ok)     head_rem_d = push_len;
                else                    head_rem_d = '0;
            end else if (commit_ok && len_cnt_q == '0) begin
                head_rem_d = push_len;
            end
        end
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        proto_d = proto_q;
        if (clear) begin
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            proto_d = 1'b0;
        end
        if (ovf_drop | commit_refused) ovf_d   = 1'b1;
        if (restart)                   proto_d = 1'b1;
        if (underflow)                 unf_d   = 1'b1;
    end

    // Register read mux; DATA words come straight from the RAM output register.
    always_comb begin
        status            = '0;
        status[PW-1:0]    = fill;
        status[23:16]     = 8'(len_cnt_q);
        status[29]        = unf_q;
        status[30]        = proto_q;
        status[31]        = ovf_q;
        rd_sel_d          = rd_sel_q;
        rd_reg_d          = rd_reg_q;
        if (rd_en) begin
            rd_sel_d = pop_data;
            case (address)
                2'd0:    rd_reg_d = status;
                2'd1:    rd_reg_d = 32'(head_rem_q);
                default: rd_reg_d = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_nios_system_packet_ring_buffer.sv
// Randomised and directed bench for the packet ring buffer, checked against
// a queue-based packet model (committed words, pending lengths, open packet).
module tb_nios_system_packet_ring_buffer;
    localparam int DW = 32, AW = 4, LFD = 4, DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic          in_valid, in_startofpacket, in_endofpacket, in_ready;
    logic [1:0]    address;
    logic          chipselect, read, write;
    logic [31:0]   writedata, readdata;
    logic          readdatavalid;

    always #5 clk = ~clk;

    nios_system_packet_ring_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_FIFO_DEPTH(LFD)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_ready(in_ready),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
    );

    // Reference model state
    int unsigned m_data[$];   // committed words, oldest first
    int          m_lens[$];   // pending packet lengths
    int unsigned m_cur[$];    // open packet being assembled
    int          m_mode;      // 0 between packets, 1 inside packet, 2 discarding to eop
    int          m_consumed;  // words already read from head packet
    bit          m_ovf, m_proto, m_unf, m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data.delete(); m_lens.delete(); m_cur.delete();
        m_mode = 0; m_consumed = 0;
        m_ovf = 0; m_proto = 0; m_unf = 0; m_ready = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r = {m_ovf, m_proto, m_unf, 5'b0, 8'(m_lens.size()), 11'b0, 5'(m_data.size())};
            2'd1: r = (m_lens.size() > 0) ? 32'(m_lens[0] - m_consumed) : 32'd0;
            2'd2: r = (m_data.size() > 0) ? m_data[0] : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_beat(input bit sop, input bit eop, input int unsigned d, input bit pop_last);
        if (m_mode == 2) begin
            if (eop) m_mode = 0;
            return;
        end
        if (m_mode == 1 && sop) begin
            m_proto = 1;
            m_cur.delete();
        end
        if (m_mode == 0 && !sop) return;
        if (m_data.size() + m_cur.size() < DEPTH) begin
            m_cur.push_back(d);
            if (eop) begin
                if (m_lens.size() - int'(pop_last) < LFD) begin
                    foreach (m_cur[i]) m_data.push_back(m_cur[i]);
                    m_lens.push_back(m_cur.size());
                end else begin
                    m_ovf = 1;
                end
                m_cur.delete();
                m_mode = 0;
            end else begin
                m_mode = 1;
            end
        end else begin
            m_ovf = 1;
            m_cur.delete();
            m_mode = eop ? 0 : 2;
        end
    endtask

    // One clock cycle: optional stream beat plus optional bus op (0 none, 1 read, 2 write).
    task automatic step(input bit v, input bit sop, input bit eop, input logic [31:0] d,
                        input int op, input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        bit is_rd, flush, clr, pop, pop_last, beat;
        in_data = d; in_valid = v; in_startofpacket = sop; in_endofpacket = eop;
        chipselect = (op != 0); read = (op == 1); write = (op == 2);
        address = a; writedata = wd;
        is_rd    = (op == 1);
        exp_rd   = is_rd ? model_read(a) : 32'd0;
        flush    = (op == 2) && (a == 2'd3) && wd[1];
        clr      = (op == 2) && (a == 2'd3) && wd[0];
        pop      = is_rd && (a == 2'd2) && (m_data.size() > 0);
        pop_last = pop && (m_lens[0] - m_consumed == 1);
        beat     = v && m_ready && !flush;
        @(posedge clk);
        if (is_rd && a == 2'd2 && m_data.size() == 0) m_unf = 1;
        if (clr) begin m_ovf = 0; m_proto = 0; m_unf = 0; end
        if (flush) begin
            m_data.delete(); m_lens.delete(); m_cur.delete(); m_consumed = 0;
            if (m_mode == 1) m_mode = 2;
        end
        if (beat) model_beat(sop, eop, d, pop_last);
        if (pop) begin
            void'(m_data.pop_front());
            m_consumed++;
            if (m_consumed == m_lens[0]) begin
                void'(m_lens.pop_front());
                m_consumed = 0;
            end
        end
        m_ready = 1;
        #1;
        if (v || op != 0)
            $display("t=%0t v=%0b sop=%0b eop=%0b d=%h op=%0d a=%0d wd=%h rdv=%0b rd=%h",
                     $time, v, sop, eop, d, op, a, wd, readdatavalid, readdata);
        check("in_ready", 32'(in_ready), 32'd1);
        check("rdvalid", 32'(readdatavalid), 32'(is_rd));
        if (is_rd) check($sformatf("read_a%0d", a), readdata, exp_rd);
        in_valid = 0; in_startofpacket = 0; in_endofpacket = 0;
        chipselect = 0; read = 0; write = 0;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) step(1, i == 0, i == n - 1, base + 32'(i), 0, 2'd0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(0, 0, 0, 32'd0, 1, a, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        step(0, 0, 0, 32'd0, 2, a, wd);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; in_data = '0; in_valid = 0; in_startofpacket = 0; in_endofpacket = 0;
        address = '0; chipselect = 0; read = 0; write = 0; writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_rdvalid", 32'(readdatavalid), 32'd0);
        @(negedge clk);
        reset_n = 1;
        step(0, 0, 0, 32'd0, 0, 2'd0, 32'd0);
        rd(2'd0);
        check("rst_status", readdata, 32'd0);

        // Single packet
        send_pkt(5, 32'hA0);
        rd(2'd0); check("single_status", readdata, 32'h0001_0005);
        rd(2'd1); check("single_headlen", readdata, 32'd5);
        for (int i = 0; i < 5; i++) begin
            rd(2'd2);
            check("single_word", readdata, 32'hA0 + 32'(i));
        end
        rd(2'd0); check("single_empty", readdata, 32'd0);

        // Drop on full
        send_pkt(12, 32'h100);
        send_pkt(6, 32'h200);
        rd(2'd0); check("full_drop", readdata, 32'h8001_000C);
        send_pkt(4, 32'h300);
        rd(2'd0); check("full_exact", readdata, 32'h8002_0010);
        wr(2'd3, 32'h3);
        rd(2'd0); check("clear_flush", readdata, 32'd0);

        // Length FIFO full
        for (int i = 0; i < 5; i++) send_pkt(1, 32'h400 + 32'(i));
        rd(2'd0); check("lenfifo_full", readdata, 32'h8004_0004);
        wr(2'd3, 32'h3);

        // Protocol restart, underflow, clear
        step(1, 1, 0, 32'h11, 0, 2'd0, 32'd0);
        step(1, 0, 0, 32'h12, 0, 2'd0, 32'd0);
        step(1, 1, 0, 32'h13, 0, 2'd0, 32'd0);
        step(1, 0, 1, 32'h14, 0, 2'd0, 32'd0);
        rd(2'd0); check("proto_status", readdata, 32'h4001_0002);
        rd(2'd2); check("proto_word", readdata, 32'h13);
        wr(2'd3, 32'h2);
        rd(2'd2); check("unf_data", readdata, 32'd0);
        rd(2'd0); check("unf_status", readdata, 32'h6000_0000);
        wr(2'd3, 32'h1);
        rd(2'd0); check("flags_clear", readdata, 32'd0);

        // Flush mid-packet, with a beat in the flush cycle
        step(1, 1, 0, 32'h21, 0, 2'd0, 32'd0);
        step(1, 0, 0, 32'h22, 0, 2'd0, 32'd0);
        step(1, 0, 0, 32'hDEAD, 2, 2'd3, 32'h2);
        rd(2'd0); check("flush_status", readdata, 32'd0);
        step(1, 0, 0, 32'h23, 0, 2'd0, 32'd0);
        step(1, 0, 1, 32'h24, 0, 2'd0, 32'd0);
        rd(2'd0); check("flush_discard", readdata, 32'd0);
        send_pkt(3, 32'h500);
        rd(2'd0); check("flush_next", readdata, 32'h0001_0003);
        for (int i = 0; i < 3; i++) rd(2'd2);

        // Wrap with simultaneous commit and last-word pop on a full length FIFO
        for (int i = 0; i < 4; i++) send_pkt(1, 32'h600 + 32'(i));
        for (int i = 4; i < 44; i++) step(1, 1, 1, 32'h600 + 32'(i), 1, 2'd2, 32'd0);
        rd(2'd0); check("wrap_status", readdata, 32'h0004_0004);
        rd(2'd2); check("wrap_word", readdata, 32'h628);
        for (int i = 0; i < 3; i++) rd(2'd2);

        // Asynchronous reset mid-packet
        step(1, 1, 0, 32'h31, 0, 2'd0, 32'd0);
        step(1, 0, 0, 32'h32, 0, 2'd0, 32'd0);
        #1 reset_n = 0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_readdata", readdata, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        step(0, 0, 0, 32'd0, 0, 2'd0, 32'd0);
        rd(2'd0); check("mid_rst_status", readdata, 32'd0);
        send_pkt(2, 32'h700);
        rd(2'd1); check("mid_rst_next", readdata, 32'd2);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            int r;
            bit v, sop, eop;
            logic [1:0] a;
            r   = int'($urandom_range(0, 99));
            v   = ($urandom_range(0, 99) < 60);
            sop = ($urandom_range(0, 3) == 0);
            eop = ($urandom_range(0, 3) == 0);
            a   = 2'($urandom_range(0, 3));
            if (r < 40)      step(v, sop, eop, $urandom, 1, a, 32'd0);
            else if (r < 43) step(v, sop, eop, $urandom, 2, 2'd3, 32'h1);
            else if (r < 45) step(v, sop, eop, $urandom, 2, 2'd3, 32'h2 | 32'($urandom_range(0, 1)));
            else if (r < 48) step(v, sop, eop, $urandom, 2, 2'($urandom_range(0, 2)), $urandom);
            else             step(v, sop, eop, $urandom, 0, 2'd0, 32'd0);
        end
        for (int i = 0; i < 4; i++) rd(2'($unsigned(i)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
